sram_march_bist: RTL

//  Synthesizable initiator for the single-port SRAM interface (the requester side of sram_m).

---
 rtl/sram_march_bist.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- BIST initiator for a single-port SRAM.
//   Runs E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0);
//   E5 up(r0). That is one SRAM op per cycle, 10*DEPTH ops in total. Read data is
//   checked at the tail of an RD_LAT-deep compare pipeline.
// Ports:
//   clk, reset (async, active high), start (accepted in IDLE only)
//   busy, done, pass, fail_count (saturating), fail_addr/fail_elem/fail_data (first miscompare)
//   sram_addr, sram_we, sram_re, sram_wdata -> SRAM;  sram_rdata <- SRAM (RD_LAT after re)
module sram_march_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic              sram_re,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        elem;
    logic [ADDR_W-1:0] addr;
    logic              phase;      // 0 = read slot, 1 = write slot of a r-then-w element
    logic [DW-1:0]     drain_cnt;

    logic accept, is_read, down, last_addr, adv, last_op, drain_last, miss;
    logic [DATA_W-1:0] rd_exp, wr_bg;

    assign accept     = (state == IDLE) && start;
    assign is_read    = (elem != 3'd0) && !phase;
    assign down       = (elem == 3'd3) || (elem == 3'd4);
    assign last_addr  = down ? (addr == '0) : (addr == '1);
    // Address moves on after the write of r/w elements, and every cycle in E0/E5.
    assign adv        = !((elem >= 3'd1) && (elem <= 3'd4) && !phase);
    assign last_op    = (elem == 3'd5) && last_addr;
    assign drain_last = (drain_cnt == DW'(RD_LAT - 1));
    assign rd_exp     = ((elem == 3'd2) || (elem == 3'd4)) ? '1 : '0;
    assign wr_bg      = ((elem == 3'd1) || (elem == 3'd3)) ? '1 : '0;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = RUN;
            RUN:     if (last_op)    state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = DONE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state == RUN) || (state == DRAIN);
        done       = (state == DONE);
        sram_addr  = (state == RUN) ? addr : '0;
        sram_re    = (state == RUN) && is_read;
        sram_we    = (state == RUN) && !is_read;
        sram_wdata = sram_we ? wr_bg : '0;
    end

    // March sequencing counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            drain_cnt <= '0;
        end else if (accept) begin
            elem      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            drain_cnt <= '0;
        end else if (state == RUN) begin
            if (!adv) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (last_addr) begin
                    elem <= elem + 3'd1;
                    // E3 and E4 sweep downwards, everything else upwards
                    addr <= ((elem == 3'd2) || (elem == 3'd3)) ? '1 : '0;
                end else begin
                    addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                end
            end
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
        end
    end

    // Compare pipeline: tail lines up with sram_rdata of the matching read
    logic [RD_LAT-1:0]             vld_pipe;
    logic [RD_LAT-1:0][DATA_W-1:0] exp_pipe;
    logic [RD_LAT-1:0][ADDR_W-1:0] addr_pipe;
    logic [RD_LAT-1:0][2:0]        elem_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            exp_pipe  <= '0;
            addr_pipe <= '0;
            elem_pipe <= '0;
        end else begin
            vld_pipe[0]  <= sram_re;
            exp_pipe[0]  <= rd_exp;
            addr_pipe[0] <= addr;
            elem_pipe[0] <= elem;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                exp_pipe[i]  <= exp_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                elem_pipe[i] <= elem_pipe[i-1];
            end
        end
    end

    assign miss = vld_pipe[RD_LAT-1] && (sram_rdata != exp_pipe[RD_LAT-1]);

    // Results. fail_count never wraps, so zero reliably marks "no miscompare yet".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
        end else if (accept) begin
            pass       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
        end else begin
            if (miss) begin
                if (fail_count == '0) begin
                    fail_addr <= addr_pipe[RD_LAT-1];
                    fail_elem <= elem_pipe[RD_LAT-1];
                    fail_data <= sram_rdata;
                end
                if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
            end
            // The last compare lands in the final DRAIN cycle, so fold it in here.
            if ((state == DRAIN) && drain_last) pass <= (fail_count == '0) && !miss;
        end
    end
endmodule
